// File: rtl/fetch_memory_responder_pkg.sv
// Shared types for the fetch memory responder: register word, Nop encoding,
// responder state enum and the address legality helper.
package fetch_memory_responder_pkg;

  typedef logic [31:0] regval_t;

  // Canonical Nop (addi x0, x0, 0) returned for illegal fetches.
  localparam regval_t NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } responder_state_t;

  // True when a byte address is misaligned or beyond the storage depth.
  function automatic logic addr_bad(input regval_t addr, input logic [31:0] depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/fetch_memory_responder_if.sv
// Fetch request/response and program-load bus between a core (master)
// and the fetch memory responder (slave).
interface fetch_memory_responder_if;
  import fetch_memory_responder_pkg::*;

  logic    address_enable;
  regval_t address;
  logic    data_valid;
  regval_t data;
  logic    fault;
  logic    load_enable;
  regval_t load_address;
  regval_t load_data;

  modport master (
    output address_enable, address, load_enable, load_address, load_data,
    input  data_valid, data, fault
  );

  modport slave (
    input  address_enable, address, load_enable, load_address, load_data,
    output data_valid, data, fault
  );
endinterface

// File: rtl/fetch_memory_responder_ram.sv
// instruction_ram: DEPTH_WORDS x 32 storage, one synchronous read port
// (1-cycle latency, read-enable gated) and one write port. No reset.
module instruction_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write-first on a same-address collision so a relaunched read sees the new word.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/fetch_memory_responder.sv
// Instruction fetch responder: IDLE/WAIT/RESPOND FSM with programmable wait
// states, redirect/abort handling, load-write coherence and fault reporting.
module fetch_memory_responder
  import fetch_memory_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int DEPTH_WORDS = 1024
) (
  input logic                     clock,
  input logic                     reset,
  fetch_memory_responder_if.slave bus
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [31:0] DW = 32'(DEPTH_WORDS);

  responder_state_t state;
  regval_t          req_addr;
  logic [3:0]       wait_count;
  logic             dv_q;
  logic             fault_q;
  regval_t          data_q;

  logic    load_ok;
  logic    load_hit;
  logic    rd_en;
  logic    req_bad;
  regval_t rd_word;

  assign load_ok  = bus.load_enable && !addr_bad(bus.load_address, DW);
  assign load_hit = load_ok && (bus.load_address[31:2] == req_addr[31:2]);
  assign req_bad  = addr_bad(req_addr, DW);

  // Read is (re)launched on every edge that (re)latches the request address.
  always_comb begin
    rd_en = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    rd_en = bus.address_enable && !bus.load_enable;
        WAIT:    rd_en = bus.address_enable && ((bus.address != req_addr) || load_hit);
        default: rd_en = 1'b0;
      endcase
    end
  end

  instruction_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clock (clock),
    .we    (load_ok && !reset),
    .waddr (bus.load_address[AW+1:2]),
    .wdata (bus.load_data),
    .re    (rd_en),
    .raddr (bus.address[AW+1:2]),
    .rdata (rd_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      wait_count <= '0;
      dv_q       <= 1'b0;
      fault_q    <= 1'b0;
      data_q     <= NOP;
    end else begin
      dv_q    <= 1'b0;
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.address_enable && !bus.load_enable) begin
            req_addr   <= bus.address;
            wait_count <= WS;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.address_enable) begin
            state <= IDLE;
          end else if ((bus.address != req_addr) || load_hit) begin
            // Redirect or overwritten target: restart the full wait.
            req_addr   <= bus.address;
            wait_count <= WS;
          end else if (wait_count == 4'd0) begin
            data_q  <= req_bad ? NOP : rd_word;
            fault_q <= req_bad;
            dv_q    <= 1'b1;
            state   <= RESPOND;
          end else begin
            wait_count <= wait_count - 4'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_valid = dv_q;
  assign bus.data       = data_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fetch_memory_responder.sv
// Self-checking bench: directed scenarios plus randomized fetches against a
// byte-address memory model; dut_a uses one wait state, dut_b none.
module tb_fetch_memory_responder;
  import fetch_memory_responder_pkg::*;

  localparam int DEPTH = 64;
  localparam int WS_A  = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [2];

  fetch_memory_responder_if ifa ();
  fetch_memory_responder_if ifb ();

  fetch_memory_responder #(.WAIT_STATES(WS_A), .DEPTH_WORDS(DEPTH)) dut_a (
    .clock (clk), .reset (rst), .bus (ifa.slave)
  );
  fetch_memory_responder #(.WAIT_STATES(0), .DEPTH_WORDS(DEPTH)) dut_b (
    .clock (clk), .reset (rst), .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected fetch result for a byte address, straight from the address rules.
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) return NOP;
    return mem_a[a >> 2];
  endfunction

  function automatic logic exp_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH));
  endfunction

  task automatic load_a(input logic [31:0] a, input logic [31:0] d);
    ifa.load_enable  = 1'b1;
    ifa.load_address = a;
    ifa.load_data    = d;
    step();
    ifa.load_enable  = 1'b0;
    if (a[1:0] == 2'b00 && a < 32'(4 * DEPTH)) mem_a[a >> 2] = d;
  endtask

  // Count edges until data_valid on dut_a, check latency/data/fault, then
  // release the request and check the pulse lasted one cycle.
  task automatic wait_resp(input string tag, input int exp_edges,
                           input logic [31:0] ed, input logic ef);
    int  k = 0;
    logic stray = 1'b0;
    do begin
      step();
      k++;
      if (!ifa.data_valid && ifa.fault) stray = 1'b1;
    end while (!ifa.data_valid && k < 40);
    chk({tag, " latency"}, 32'(k), 32'(exp_edges));
    chk({tag, " data"}, ifa.data, ed);
    chk({tag, " fault"}, 32'(ifa.fault), 32'(ef));
    chk({tag, " fault-without-valid"}, 32'(stray), 32'd0);
    ifa.address_enable = 1'b0;
    step();
    chk({tag, " valid-one-cycle"}, 32'(ifa.data_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a, a2, d;
    int dv_cnt, n, cyc;
    int t [4];
    logic prev_dv;

    rst = 1'b1;
    ifa.address_enable = 1'b0; ifa.address = '0;
    ifa.load_enable = 1'b0; ifa.load_address = '0; ifa.load_data = '0;
    ifb.address_enable = 1'b0; ifb.address = '0;
    ifb.load_enable = 1'b0; ifb.load_address = '0; ifb.load_data = '0;
    step(); step();
    chk("reset a valid", 32'(ifa.data_valid), 32'd0);
    chk("reset a fault", 32'(ifa.fault), 32'd0);
    chk("reset a data", ifa.data, NOP);
    chk("reset b data", ifb.data, NOP);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load_a(32'(4 * i), $urandom());
    load_a(32'h40, 32'h1234_5678);

    // Basic fetch: sampled on the first edge, valid WS_A+1 edges later.
    ifa.address_enable = 1'b1; ifa.address = 32'h40;
    wait_resp("basic 0x40", WS_A + 2, 32'h1234_5678, 1'b0);

    // Redirect one cycle into the wait.
    ifa.address_enable = 1'b1; ifa.address = 32'h40;
    step();
    chk("redirect early valid", 32'(ifa.data_valid), 32'd0);
    ifa.address = 32'h80;
    wait_resp("redirect 0x80", WS_A + 2, exp_word(32'h80), 1'b0);

    ifa.address_enable = 1'b1; ifa.address = 32'h42;
    wait_resp("misaligned", WS_A + 2, NOP, 1'b1);
    ifa.address_enable = 1'b1; ifa.address = 32'(4 * DEPTH);
    wait_resp("out of range", WS_A + 2, NOP, 1'b1);

    // Load to the pending word restarts the wait from the load edge.
    ifa.address_enable = 1'b1; ifa.address = 32'h40;
    step();
    load_a(32'h40, 32'hCAFE_F00D);
    wait_resp("load hit", WS_A + 1, 32'hCAFE_F00D, 1'b0);

    // Reset mid-wait discards the request; storage survives.
    ifa.address_enable = 1'b1; ifa.address = 32'h40;
    step();
    rst = 1'b1;
    step();
    chk("reset mid valid", 32'(ifa.data_valid), 32'd0);
    chk("reset mid data", ifa.data, NOP);
    rst = 1'b0;
    wait_resp("after reset", WS_A + 2, 32'hCAFE_F00D, 1'b0);

    // Reset wins over a same-edge load write.
    rst = 1'b1;
    ifa.load_enable = 1'b1; ifa.load_address = 32'h0; ifa.load_data = 32'hDEAD_BEEF;
    step();
    rst = 1'b0; ifa.load_enable = 1'b0;
    ifa.address_enable = 1'b1; ifa.address = 32'h0;
    wait_resp("reset blocks load", WS_A + 2, exp_word(32'h0), 1'b0);

    // Illegal loads are dropped (they would alias words 0 and 1).
    load_a(32'(4 * DEPTH), 32'hBAD0_0001);
    load_a(32'h6, 32'hBAD0_0002);
    ifa.address_enable = 1'b1; ifa.address = 32'h0;
    wait_resp("oor load ignored", WS_A + 2, exp_word(32'h0), 1'b0);
    ifa.address_enable = 1'b1; ifa.address = 32'h4;
    wait_resp("misaligned load ignored", WS_A + 2, exp_word(32'h4), 1'b0);

    // Load and request on the same IDLE edge: write first, request next edge.
    ifa.address_enable = 1'b1; ifa.address = 32'h8;
    load_a(32'h8, 32'h0BAD_CAFE);
    wait_resp("idle load priority", WS_A + 2, 32'h0BAD_CAFE, 1'b0);

    // Abort: dropping the request yields no response.
    ifa.address_enable = 1'b1; ifa.address = 32'h44;
    step();
    ifa.address_enable = 1'b0;
    dv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifa.data_valid) dv_cnt++;
    end
    chk("abort no response", 32'(dv_cnt), 32'd0);

    // Randomized fetches, loads and redirects.
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 9);
      if (n < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (n == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else             a = 32'(4 * DEPTH + $urandom_range(0, 1000) * 4);
      if ($urandom_range(0, 3) == 0) load_a(32'($urandom_range(0, DEPTH - 1) * 4), $urandom());
      ifa.address_enable = 1'b1; ifa.address = a;
      if ($urandom_range(0, 3) == 0) begin
        step();
        a2 = 32'($urandom_range(0, DEPTH - 1) * 4);
        if (a2 == a) a2 = a ^ 32'h4;
        a = a2;
        ifa.address = a;
      end
      wait_resp($sformatf("rand%0d", it), WS_A + 2, exp_word(a), exp_fault(a));
    end

    // Zero wait states: back-to-back requests 0x0 then 0x4.
    for (int i = 0; i < 2; i++) begin
      d = $urandom();
      mem_b[i] = d;
      ifb.load_enable = 1'b1; ifb.load_address = 32'(4 * i); ifb.load_data = d;
      step();
    end
    ifb.load_enable = 1'b0;
    ifb.address_enable = 1'b1; ifb.address = 32'h0;
    n = 0; cyc = 0; prev_dv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      cyc++;
      if (ifb.data_valid) begin
        chk("b2b single pulse", 32'(prev_dv), 32'd0);
        if (n < 2) begin
          chk($sformatf("b2b data%0d", n), ifb.data, mem_b[n]);
          chk($sformatf("b2b fault%0d", n), 32'(ifb.fault), 32'd0);
        end
        if (n < 4) t[n] = cyc;
        n++;
        if (n == 1) ifb.address = 32'h4;
        if (n == 2) ifb.address_enable = 1'b0;
      end
      prev_dv = ifb.data_valid;
    end
    chk("b2b response count", 32'(n), 32'd2);
    if (n >= 2) chk("b2b spacing", 32'(t[1] - t[0]), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
